// File: rtl/i2c_transaction_sequencer_if.sv
// Request/bus bundle between a transaction client and the I2C transaction sequencer.
// i_req is a one-cycle pulse taken only while o_busy=0 and the sequencer is idle;
// o_done pulses once per accepted request, and o_busy covers START through STOP.
interface i2c_transaction_sequencer_if;
    logic        i_req;
    logic        i_rw;
    logic [6:0]  i_addr;
    logic [2:0]  i_len;
    logic [31:0] i_wdata;
    logic        i_t_HD_STA_done;
    logic        i_t_HD_DAT_done;
    logic        i_t_Catch_ACK_done;
    logic        i_t_HIGH_done;
    logic        i_sda_in;
    logic [4:0]  o_cmd_state;
    logic        o_sda_oe;
    logic        o_busy;
    logic        o_done;
    logic        o_nack;
    logic [31:0] o_rdata;

    modport master (
        input  i_req, i_rw, i_addr, i_len, i_wdata,
        input  i_t_HD_STA_done, i_t_HD_DAT_done, i_t_Catch_ACK_done, i_t_HIGH_done, i_sda_in,
        output o_cmd_state, o_sda_oe, o_busy, o_done, o_nack, o_rdata
    );

    modport slave (
        output i_req, i_rw, i_addr, i_len, i_wdata,
        output i_t_HD_STA_done, i_t_HD_DAT_done, i_t_Catch_ACK_done, i_t_HIGH_done, i_sda_in,
        input  o_cmd_state, o_sda_oe, o_busy, o_done, o_nack, o_rdata
    );
endinterface

// File: rtl/i2c_transaction_sequencer.sv
// I2C master transaction sequencer: START, address byte, 1-4 payload bytes with ACK/NACK, STOP.
// Bit timing comes from an external timing block through one-cycle strobes.
module i2c_transaction_sequencer #(
    parameter logic [3:0] CMD_IDLE          = 4'b0000,
    parameter logic [3:0] CMD_START         = 4'b0001,
    parameter logic [3:0] CMD_DATA_TRANSFER = 4'b0010,
    parameter logic [3:0] CMD_CATCH_ACK     = 4'b0011,
    parameter logic [3:0] CMD_STOP          = 4'b0101
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    i2c_transaction_sequencer_if.master        bus,
    output logic [2:0]                         o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        addr_phase_q, addr_phase_d;
    logic        sda_oe_q, sda_oe_d;
    logic        nack_q, nack_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  len_clamped;
    logic        rx_byte;
    logic        last_byte;
    logic [3:0]  cmd;

    assign len_clamped = (bus.i_len == 3'd0) ? 3'd1 :
                         (bus.i_len > 3'd4)  ? 3'd4 : bus.i_len;
    // Only payload bytes of a read are received; the address byte is always driven.
    assign rx_byte   = rw_q & ~addr_phase_q;
    assign last_byte = ({1'b0, byte_idx_q} == (len_q - 3'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            wdata_q      <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            addr_phase_q <= 1'b0;
            sda_oe_q     <= 1'b0;
            nack_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            addr_phase_q <= addr_phase_d;
            sda_oe_q     <= sda_oe_d;
            nack_q       <= nack_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wdata_d      = wdata_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        addr_phase_d = addr_phase_q;
        sda_oe_d     = sda_oe_q;
        nack_d       = nack_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    rw_d         = bus.i_rw;
                    addr_d       = bus.i_addr;
                    len_d        = len_clamped;
                    wdata_d      = bus.i_wdata;
                    rdata_d      = '0;
                    nack_d       = 1'b0;
                    bit_cnt_d    = '0;
                    byte_idx_d   = '0;
                    addr_phase_d = 1'b1;
                    sda_oe_d     = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (bus.i_t_HD_STA_done) begin
                    shift_d   = {addr_q, rw_q};
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_byte) begin
                    if (bus.i_t_Catch_ACK_done) shift_d = {shift_q[6:0], bus.i_sda_in};
                end else if (bus.i_t_HD_DAT_done) begin
                    sda_oe_d = ~shift_q[3'd7 - bit_cnt_q];
                end
                // shift_d already holds a coincident sample, so the stored byte includes it.
                if (bus.i_t_HIGH_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = S_ACK;
                        if (rx_byte) rdata_d[{byte_idx_q, 3'b000} +: 8] = shift_d;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (!rx_byte) begin
                    if (bus.i_t_Catch_ACK_done && bus.i_sda_in) nack_d = 1'b1;
                end else if (bus.i_t_HD_DAT_done) begin
                    sda_oe_d = ~last_byte;
                end
                if (bus.i_t_HIGH_done) begin
                    if (nack_d || (!addr_phase_q && last_byte)) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_STOP;
                    end else begin
                        byte_idx_d   = addr_phase_q ? 2'd0 : byte_idx_q + 2'd1;
                        addr_phase_d = 1'b0;
                        bit_cnt_d    = '0;
                        shift_d      = rw_q ? 8'h00 : wdata_q[{byte_idx_d, 3'b000} +: 8];
                        if (rw_q) sda_oe_d = 1'b0;
                        state_d      = S_DATA;
                    end
                end
            end
            S_STOP: begin
                if (bus.i_t_HIGH_done) begin
                    sda_oe_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd        = CMD_IDLE;
        bus.o_busy = 1'b0;
        bus.o_done = 1'b0;
        case (state_q)
            S_START: begin cmd = CMD_START;         bus.o_busy = 1'b1; end
            S_DATA:  begin cmd = CMD_DATA_TRANSFER; bus.o_busy = 1'b1; end
            S_ACK:   begin cmd = CMD_CATCH_ACK;     bus.o_busy = 1'b1; end
            S_STOP:  begin cmd = CMD_STOP;          bus.o_busy = 1'b1; end
            S_DONE:  bus.o_done = 1'b1;
            default: cmd = CMD_IDLE;
        endcase
        bus.o_cmd_state = {1'b0, cmd};
    end

    assign bus.o_sda_oe = sda_oe_q;
    assign bus.o_nack   = nack_q;
    assign bus.o_rdata  = rdata_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed bench for the I2C transaction sequencer: strobe-level driver, hand-computed SDA patterns.
`timescale 1ns/1ps
module tb_i2c_transaction_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         n_checks;
    int         n_fail;
    logic [8:0] oe_log [0:4];
    logic       start_oe;

    i2c_transaction_sequencer_if bus();

    i2c_transaction_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0=HD_STA 1=HD_DAT 2=Catch_ACK 3=HIGH 4=Catch_ACK+HIGH together
    task automatic pulse(input int which);
        bus.i_t_HD_STA_done    = (which == 0);
        bus.i_t_HD_DAT_done    = (which == 1);
        bus.i_t_Catch_ACK_done = (which == 2) || (which == 4);
        bus.i_t_HIGH_done      = (which == 3) || (which == 4);
        @(posedge clk); #1;
        bus.i_t_HD_STA_done    = 1'b0;
        bus.i_t_HD_DAT_done    = 1'b0;
        bus.i_t_Catch_ACK_done = 1'b0;
        bus.i_t_HIGH_done      = 1'b0;
    endtask

    task automatic bit_cycle(input logic sbit, input logic together, output logic oe);
        bus.i_sda_in = sbit;
        pulse(1);
        oe = bus.o_sda_oe;
        if (together) pulse(4);
        else begin
            pulse(2);
            pulse(3);
        end
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata, input logic [31:0] sdata, input logic addr_nack,
                           input int nbytes, input logic together, input logic inject,
                           input int abort_b);
        logic oe;
        logic sb;
        int   idx;
        for (int k = 0; k < 5; k++) oe_log[k] = '0;
        bus.i_rw = rw; bus.i_addr = addr; bus.i_len = len; bus.i_wdata = wdata;
        bus.i_req = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        check("busy_after_req", {31'd0, bus.o_busy}, 32'd1);
        check("cmd_start", {27'd0, bus.o_cmd_state}, 32'd1);
        start_oe = bus.o_sda_oe;
        pulse(0);
        for (int b = 0; b <= nbytes; b++) begin
            if (inject && b == 1) begin
                bus.i_rw = ~rw; bus.i_addr = 7'h7F; bus.i_len = 3'd4; bus.i_wdata = 32'hFFFF_FFFF;
                bus.i_req = 1'b1;
                @(posedge clk); #1;
                bus.i_req = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                if (b == abort_b && i == 4) return;
                sb = 1'b0;
                if (rw && b > 0) begin
                    idx = 8 * (b - 1) + 7 - i;
                    sb  = sdata[idx];
                end
                bit_cycle(sb, together, oe);
                oe_log[b][8 - i] = oe;
            end
            sb = (b == 0) ? addr_nack : rw;
            bit_cycle(sb, together, oe);
            oe_log[b][0] = oe;
            if (b == 0 && addr_nack) break;
        end
        check("cmd_stop", {27'd0, bus.o_cmd_state}, 32'd5);
        check("stop_oe_low", {31'd0, bus.o_sda_oe}, 32'd1);
        pulse(3);
        check("done_pulse", {31'd0, bus.o_done}, 32'd1);
        check("busy_in_done", {31'd0, bus.o_busy}, 32'd0);
        check("stop_oe_release", {31'd0, bus.o_sda_oe}, 32'd0);
        check("cmd_idle_done", {27'd0, bus.o_cmd_state}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, {27'd0, bus.o_cmd_state}, 32'd0);
        check({tag, "_oe"}, {31'd0, bus.o_sda_oe}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
        check({tag, "_nack"}, {31'd0, bus.o_nack}, 32'd0);
        check({tag, "_rdata"}, bus.o_rdata, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.i_req = 1'b0; bus.i_rw = 1'b0; bus.i_addr = '0; bus.i_len = '0; bus.i_wdata = '0;
        bus.i_t_HD_STA_done = 1'b0; bus.i_t_HD_DAT_done = 1'b0;
        bus.i_t_Catch_ACK_done = 1'b0; bus.i_t_HIGH_done = 1'b0;
        bus.i_sda_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0x50, one byte 0xA5: address 1010_0000, data 1010_0101, SDA oe is inverted.
        run_txn(1'b0, 7'h50, 3'd1, 32'h0000_00A5, 32'd0, 1'b0, 1, 1'b0, 1'b0, -1);
        check("wr_start_oe", {31'd0, start_oe}, 32'd1);
        check("wr_addr_bits", {23'd0, oe_log[0]}, {23'd0, 8'h5F, 1'b0});
        check("wr_data_bits", {23'd0, oe_log[1]}, {23'd0, 8'h5A, 1'b0});
        check("wr_nack", {31'd0, bus.o_nack}, 32'd0);

        // Read 0x3C, two bytes 0x12, 0x34 with sample and advance strobes coinciding.
        run_txn(1'b1, 7'h3C, 3'd2, 32'd0, 32'h0000_3412, 1'b0, 2, 1'b1, 1'b0, -1);
        check("rd_addr_bits", {23'd0, oe_log[0]}, {23'd0, 8'h86, 1'b0});
        check("rd_byte0_ack", {23'd0, oe_log[1]}, {23'd0, 8'h00, 1'b1});
        check("rd_byte1_nack", {23'd0, oe_log[2]}, {23'd0, 8'h00, 1'b0});
        check("rd_rdata", bus.o_rdata, 32'h0000_3412);
        check("rd_nack", {31'd0, bus.o_nack}, 32'd0);

        // Address NACK, sampled in the same cycle as the advance.
        run_txn(1'b0, 7'h50, 3'd3, 32'h1122_3344, 32'd0, 1'b1, 0, 1'b1, 1'b0, -1);
        check("an_addr_bits", {23'd0, oe_log[0]}, {23'd0, 8'h5F, 1'b0});
        check("an_nack", {31'd0, bus.o_nack}, 32'd1);
        check("an_rdata_cleared", bus.o_rdata, 32'd0);

        // len=0 sends one byte (0xAA).
        run_txn(1'b0, 7'h50, 3'd0, 32'hDDCC_BBAA, 32'd0, 1'b0, 1, 1'b0, 1'b0, -1);
        check("len0_byte0", {23'd0, oe_log[1]}, {23'd0, 8'h55, 1'b0});
        check("len0_nack_cleared", {31'd0, bus.o_nack}, 32'd0);

        // len=7 clamps to four bytes AA, BB, CC, DD.
        run_txn(1'b0, 7'h50, 3'd7, 32'hDDCC_BBAA, 32'd0, 1'b0, 4, 1'b0, 1'b0, -1);
        check("len7_byte0", {23'd0, oe_log[1]}, {23'd0, 8'h55, 1'b0});
        check("len7_byte1", {23'd0, oe_log[2]}, {23'd0, 8'h44, 1'b0});
        check("len7_byte2", {23'd0, oe_log[3]}, {23'd0, 8'h33, 1'b0});
        check("len7_byte3", {23'd0, oe_log[4]}, {23'd0, 8'h22, 1'b0});

        // Request pulsed during DATA must not disturb the running write.
        run_txn(1'b0, 7'h50, 3'd1, 32'h0000_00A5, 32'd0, 1'b0, 1, 1'b0, 1'b1, -1);
        check("inj_addr_bits", {23'd0, oe_log[0]}, {23'd0, 8'h5F, 1'b0});
        check("inj_data_bits", {23'd0, oe_log[1]}, {23'd0, 8'h5A, 1'b0});
        check("inj_rdata", bus.o_rdata, 32'd0);
        @(posedge clk); #1;
        check("inj_idle", {31'd0, bus.o_busy}, 32'd0);

        // Reset asserted mid-bit 4 of payload byte 1 of a read.
        run_txn(1'b1, 7'h3C, 3'd2, 32'd0, 32'h0000_3412, 1'b0, 2, 1'b0, 1'b0, 2);
        check("abort_busy_before", {31'd0, bus.o_busy}, 32'd1);
        check("abort_rdata_before", bus.o_rdata, 32'h0000_0012);
        #20;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 7'h50, 3'd1, 32'h0000_00A5, 32'd0, 1'b0, 1, 1'b0, 1'b0, -1);
        check("post_rst_addr", {23'd0, oe_log[0]}, {23'd0, 8'h5F, 1'b0});
        check("post_rst_data", {23'd0, oe_log[1]}, {23'd0, 8'h5A, 1'b0});
        check("post_rst_nack", {31'd0, bus.o_nack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
